// File: rtl/wheel_odometer_if.sv
// Signal bundle between the motion FSM (master) and one per-wheel odometry front end (slave).
interface wheel_odometer_if;
    logic               enable;
    logic               dir;
    logic               drive;
    logic               encdr;
    logic signed [10:0] rev;
    logic signed [10:0] deg;
    logic               tick;
    logic               stall;

    modport master (
        output enable, dir, drive, encdr,
        input  rev, deg, tick, stall
    );

    modport slave (
        input  enable, dir, drive, encdr,
        output rev, deg, tick, stall
    );
endinterface

// File: rtl/wheel_odometer.sv
// Per-wheel odometry: synchronise and glitch-filter one encoder channel, count rising
// edges into signed revolutions/degrees, and flag a stalled wheel while driven.
module wheel_odometer #(
    parameter int unsigned FILTER_CYCLES = 4,
    parameter int unsigned STEP_DEG      = 1,
    parameter int unsigned STALL_CYCLES  = 16_000_000
) (
    input logic             WF_CLK,
    input logic             rst,
    wheel_odometer_if.slave bus
);

    localparam int unsigned        FW        = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0]      FILT_LIM  = FW'(FILTER_CYCLES);
    localparam logic [23:0]        STALL_LIM = 24'(STALL_CYCLES);
    localparam logic signed [10:0] STEP      = 11'(STEP_DEG);
    localparam logic signed [10:0] FULL_POS  = 11'sd360;
    localparam logic signed [10:0] FULL_NEG  = -11'sd360;
    localparam logic signed [10:0] REV_MAX   = 11'sd1023;
    localparam logic signed [10:0] REV_MIN   = 11'b100_0000_0000;

    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [FW-1:0]      filt_cnt_q, filt_cnt_d;
    logic               filt_q, filt_d;
    logic               prev_q, prev_d;
    logic               tick_q, tick_d;
    logic signed [10:0] rev_q, rev_d;
    logic signed [10:0] deg_q, deg_d;
    logic [23:0]        stall_cnt_q, stall_cnt_d;
    logic               stall_q, stall_d;

    logic               acc_edge;
    logic signed [10:0] deg_step;
    logic               stall_clr;

    always_comb begin
        sync1_d = bus.encdr;
        sync2_d = sync1_q;

        // Counter sits at the limit for one cycle, then the level follows whatever is synchronised then.
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (filt_cnt_q == FILT_LIM) begin
            filt_d     = sync2_q;
            filt_cnt_d = '0;
        end else if (sync2_q != filt_q) begin
            filt_cnt_d = filt_cnt_q + 1'b1;
        end

        prev_d   = filt_q;
        acc_edge = filt_q & ~prev_q & bus.enable;
        tick_d   = acc_edge;

        deg_step = bus.dir ? (deg_q - STEP) : (deg_q + STEP);
        rev_d    = rev_q;
        deg_d    = deg_q;
        if (!bus.enable) begin
            rev_d = '0;
            deg_d = '0;
        end else if (acc_edge) begin
            if (deg_step >= FULL_POS) begin
                if (rev_q != REV_MAX) begin
                    rev_d = rev_q + 11'sd1;
                    deg_d = deg_step - FULL_POS;
                end
            end else if (deg_step <= FULL_NEG) begin
                if (rev_q != REV_MIN) begin
                    rev_d = rev_q - 11'sd1;
                    deg_d = deg_step + FULL_POS;
                end
            end else begin
                deg_d = deg_step;
            end
        end

        // Visible tick pulse clears the watchdog, so stall drops one cycle after the tick.
        stall_clr   = !bus.enable || !bus.drive || tick_q;
        stall_cnt_d = stall_cnt_q;
        stall_d     = 1'b0;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else begin
            if (stall_cnt_q != STALL_LIM) begin
                stall_cnt_d = stall_cnt_q + 24'd1;
            end
            stall_d = (stall_cnt_d == STALL_LIM);
        end
    end

    always_ff @(posedge WF_CLK or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            filt_cnt_q  <= '0;
            filt_q      <= 1'b0;
            prev_q      <= 1'b0;
            tick_q      <= 1'b0;
            rev_q       <= '0;
            deg_q       <= '0;
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            filt_cnt_q  <= filt_cnt_d;
            filt_q      <= filt_d;
            prev_q      <= prev_d;
            tick_q      <= tick_d;
            rev_q       <= rev_d;
            deg_q       <= deg_d;
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.rev   = rev_q;
    assign bus.deg   = deg_q;
    assign bus.tick  = tick_q;
    assign bus.stall = stall_q;

endmodule

// File: tb/tb_wheel_odometer.sv
// Scoreboard bench: two odometer instances (1-degree steps, and whole-revolution steps for saturation).
`timescale 1ns/1ps
module tb_wheel_odometer;

    logic WF_CLK = 1'b0;
    logic rst;
    always #5 WF_CLK = ~WF_CLK;

    wheel_odometer_if ifa();
    wheel_odometer_if ifb();

    wheel_odometer #(.FILTER_CYCLES(4), .STEP_DEG(1), .STALL_CYCLES(100)) dut_a (
        .WF_CLK(WF_CLK), .rst(rst), .bus(ifa)
    );
    wheel_odometer #(.FILTER_CYCLES(1), .STEP_DEG(360), .STALL_CYCLES(100)) dut_b (
        .WF_CLK(WF_CLK), .rst(rst), .bus(ifb)
    );

    typedef struct {
        int rev;
        int deg;
    } pos_t;

    pos_t qa[$];
    pos_t qb[$];
    pos_t ea, eb;
    int checks = 0;
    int failures = 0;
    int ticks_a = 0;
    int ticks_b = 0;
    int ma_rev = 0, ma_deg = 0, mb_rev = 0, mb_deg = 0;
    int t0, lat, hi, lo;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: position as (rev, deg) with the wrap/saturation rules applied per accepted edge.
    function automatic void model_step(input int step, input bit dir, inout int r, inout int d);
        int nd;
        nd = dir ? d - step : d + step;
        if (nd >= 360) begin
            if (r < 1023) begin r = r + 1; d = nd - 360; end
        end else if (nd <= -360) begin
            if (r > -1024) begin r = r - 1; d = nd + 360; end
        end else begin
            d = nd;
        end
    endfunction

    task automatic pulse_a(input int h, input int l);
        pos_t e;
        if (h >= 5 && ifa.enable) begin
            model_step(1, ifa.dir, ma_rev, ma_deg);
            e.rev = ma_rev; e.deg = ma_deg;
            qa.push_back(e);
        end
        ifa.encdr = 1'b1;
        repeat (h) @(negedge WF_CLK);
        ifa.encdr = 1'b0;
        repeat (l) @(negedge WF_CLK);
    endtask

    task automatic pulse_b(input int h, input int l);
        pos_t e;
        if (h >= 2 && ifb.enable) begin
            model_step(360, ifb.dir, mb_rev, mb_deg);
            e.rev = mb_rev; e.deg = mb_deg;
            qb.push_back(e);
        end
        ifb.encdr = 1'b1;
        repeat (h) @(negedge WF_CLK);
        ifb.encdr = 1'b0;
        repeat (l) @(negedge WF_CLK);
    endtask

    task automatic drain_a();
        for (int i = 0; i < 40 && qa.size() != 0; i++) @(negedge WF_CLK);
        #1;
        chk("a_drain", qa.size(), 0);
    endtask

    task automatic drain_b();
        for (int i = 0; i < 40 && qb.size() != 0; i++) @(negedge WF_CLK);
        #1;
        chk("b_drain", qb.size(), 0);
    endtask

    always @(negedge WF_CLK) begin
        if (!rst && ifa.tick) begin
            ticks_a++;
            if (qa.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_unexpected_tick actual=1 required=0");
            end else begin
                ea = qa.pop_front();
                chk("a_rev", ifa.rev, ea.rev);
                chk("a_deg", ifa.deg, ea.deg);
            end
        end
    end

    always @(negedge WF_CLK) begin
        if (!rst && ifb.tick) begin
            ticks_b++;
            if (qb.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected_tick actual=1 required=0");
            end else begin
                eb = qb.pop_front();
                chk("b_rev", ifb.rev, eb.rev);
                chk("b_deg", ifb.deg, eb.deg);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ifa.enable = 1'b0; ifa.dir = 1'b0; ifa.drive = 1'b0; ifa.encdr = 1'b0;
        ifb.enable = 1'b0; ifb.dir = 1'b0; ifb.drive = 1'b0; ifb.encdr = 1'b0;
        repeat (3) @(negedge WF_CLK);
        chk("rst_rev", ifa.rev, 0);
        chk("rst_deg", ifa.deg, 0);
        chk("rst_tick", ifa.tick, 0);
        chk("rst_stall", ifa.stall, 0);
        rst = 1'b0;

        // Forward counting
        ifa.enable = 1'b1; ifa.dir = 1'b0;
        t0 = ticks_a;
        for (int i = 0; i < 360; i++) pulse_a(8, 8);
        drain_a();
        chk("t1_rev", ifa.rev, 1);
        chk("t1_deg", ifa.deg, 0);
        chk("t1_ticks", ticks_a - t0, 360);
        for (int i = 0; i < 180; i++) pulse_a(8, 8);
        drain_a();
        chk("t1b_rev", ifa.rev, 1);
        chk("t1b_deg", ifa.deg, 180);

        // Reverse with mixed-sign result
        ifa.enable = 1'b0; ma_rev = 0; ma_deg = 0;
        repeat (2) @(negedge WF_CLK);
        chk("t2_clr_deg", ifa.deg, 0);
        ifa.enable = 1'b1; ifa.dir = 1'b1;
        for (int i = 0; i < 361; i++) pulse_a(8, 8);
        drain_a();
        chk("t2_rev", ifa.rev, -1);
        chk("t2_deg", ifa.deg, -1);
        ifa.dir = 1'b0;
        pulse_a(8, 8);
        drain_a();
        chk("t2b_rev", ifa.rev, -1);
        chk("t2b_deg", ifa.deg, 0);

        // Glitch filter and latency
        t0 = ticks_a;
        pulse_a(2, 10);
        pulse_a(4, 10);
        drain_a();
        chk("t3_glitch_ticks", ticks_a - t0, 0);
        chk("t3_glitch_deg", ifa.deg, ma_deg);
        lat = -1;
        fork
            pulse_a(5, 10);
            begin
                @(posedge WF_CLK);
                for (int k = 1; k <= 20; k++) begin
                    @(posedge WF_CLK); #1;
                    if (ifa.tick && lat < 0) lat = k;
                end
            end
        join
        drain_a();
        chk("t3_latency", lat, 7);
        chk("t3_ticks", ticks_a - t0, 1);

        // Randomised pulses and glitches
        for (int i = 0; i < 80; i++) begin
            ifa.dir = 1'($urandom_range(0, 1));
            hi = $urandom_range(1, 9);
            lo = $urandom_range(5, 9);
            pulse_a(hi, lo);
        end
        drain_a();
        chk("rnd_rev", ifa.rev, ma_rev);
        chk("rnd_deg", ifa.deg, ma_deg);

        // Stall watchdog
        @(negedge WF_CLK);
        ifa.drive = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge WF_CLK); #1;
            if (n == 99) chk("t4_stall_99", ifa.stall, 0);
            if (n == 100) chk("t4_stall_100", ifa.stall, 1);
        end
        @(negedge WF_CLK);
        lat = -1;
        fork
            pulse_a(5, 10);
            begin
                for (int k = 1; k <= 20 && lat < 0; k++) begin
                    @(posedge WF_CLK); #1;
                    if (ifa.tick) lat = k;
                end
                chk("t4_tick_seen", ifa.tick, 1);
                @(posedge WF_CLK); #1;
                chk("t4_stall_after_tick", ifa.stall, 0);
            end
        join
        drain_a();
        for (int k = 0; k < 150 && !ifa.stall; k++) @(negedge WF_CLK);
        chk("t4_stall_rearm", ifa.stall, 1);
        @(negedge WF_CLK);
        ifa.drive = 1'b0;
        @(posedge WF_CLK); #1;
        chk("t4_stall_drive0", ifa.stall, 0);

        // Enable clear, disabled pulses, enabling with line high
        @(negedge WF_CLK);
        ifa.enable = 1'b0; ma_rev = 0; ma_deg = 0;
        repeat (2) @(negedge WF_CLK);
        ifa.enable = 1'b1; ifa.dir = 1'b0;
        for (int i = 0; i < 1125; i++) pulse_a(5, 5);
        drain_a();
        chk("t5_rev", ifa.rev, 3);
        chk("t5_deg", ifa.deg, 45);
        @(negedge WF_CLK);
        ifa.enable = 1'b0; ma_rev = 0; ma_deg = 0;
        @(posedge WF_CLK); #1;
        chk("t5_clr_rev", ifa.rev, 0);
        chk("t5_clr_deg", ifa.deg, 0);
        t0 = ticks_a;
        @(negedge WF_CLK);
        for (int i = 0; i < 3; i++) pulse_a(8, 8);
        ifa.encdr = 1'b1;
        repeat (12) @(negedge WF_CLK);
        ifa.enable = 1'b1;
        repeat (12) @(negedge WF_CLK);
        ifa.encdr = 1'b0;
        repeat (12) @(negedge WF_CLK);
        chk("t5_dis_ticks", ticks_a - t0, 0);
        chk("t5_dis_deg", ifa.deg, 0);
        for (int i = 0; i < 3; i++) pulse_a(8, 8);
        drain_a();
        chk("t5_pre_rst_deg", ifa.deg, 3);

        // Asynchronous reset mid-pulse
        @(negedge WF_CLK);
        ifa.encdr = 1'b1;
        repeat (2) @(negedge WF_CLK);
        #2 rst = 1'b1;
        #1;
        chk("t5_arst_rev", ifa.rev, 0);
        chk("t5_arst_deg", ifa.deg, 0);
        chk("t5_arst_tick", ifa.tick, 0);
        chk("t5_arst_stall", ifa.stall, 0);
        ifa.encdr = 1'b0; ma_rev = 0; ma_deg = 0;
        qa.delete();
        repeat (3) @(negedge WF_CLK);
        rst = 1'b0;
        repeat (12) @(negedge WF_CLK);
        chk("t5_post_rst_deg", ifa.deg, 0);

        // Saturation at both rev limits
        ifb.enable = 1'b1; ifb.dir = 1'b0;
        t0 = ticks_b;
        for (int i = 0; i < 1030; i++) pulse_b(3, 3);
        drain_b();
        chk("t6_sat_hi_rev", ifb.rev, 1023);
        chk("t6_sat_hi_deg", ifb.deg, 0);
        chk("t6_sat_hi_ticks", ticks_b - t0, 1030);
        ifb.dir = 1'b1;
        for (int i = 0; i < 2052; i++) pulse_b(3, 3);
        drain_b();
        chk("t6_sat_lo_rev", ifb.rev, -1024);
        chk("t6_sat_lo_deg", ifb.deg, 0);
        ifb.dir = 1'b0;
        pulse_b(3, 3);
        drain_b();
        chk("t6_unsat_rev", ifb.rev, -1023);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wheel_odometer.md
Name: wheel_odometer

Overview:
Per-wheel odometry front end between a raw TI-RSLK-MAX wheel encoder channel and the motion state machine in fpga_top.
- Synchronises and glitch-filters the encoder input and counts rising edges.
- Produces signed revolution and degree counts that the FSM compares against targets such as one revolution or 180 degrees.
- Flags a stalled wheel when the motor is driven but no encoder edges arrive.
- One instance per wheel.

Parameters:
FILTER_CYCLES, 4, consecutive WF_CLK cycles the synchronised input must hold a new level before the filtered level changes (min 1).
STEP_DEG, 1, degrees added per accepted edge; must divide 360.
STALL_CYCLES, 16_000_000, driven-without-edge WF_CLK cycles before stall asserts (1 s at 16 MHz; 24-bit counter).

Ports:
WF_CLK  in  1  system clock (16 MHz)
rst  in  1  reset, asynchronous, active-high
enable  in  1  1 = count; 0 = hold rev/deg cleared
dir  in  1  0 = forward (count up), 1 = reverse (count down)
drive  in  1  motor currently commanded to move
encdr  in  1  raw encoder channel, asynchronous to WF_CLK
rev  out  11  signed whole revolutions
deg  out  11  signed degrees within revolution, range -359..+359
tick  out  1  one-cycle strobe per accepted edge
stall  out  1  wheel-stalled flag

Behaviour:
- Reset (async, active-high): the following are all zero:
  - outputs rev, deg, tick, stall;
  - the synchroniser flops;
  - the filter counter and filtered level;
  - the previous-level register;
  - the stall counter.
- Input path:
  - 2-flop synchroniser on encdr.
  - Filter: a counter increments while the synchronised value differs from the filtered level and resets to 0 when they match.
  - When the counter reaches FILTER_CYCLES, the filtered level takes the synchronised value and the counter clears.
- Edge detection:
  - An accepted edge is filtered rising (filtered=1, prev=0), with enable=1.
  - prev tracks filtered every cycle regardless of enable, so enabling while the line is high does not count.
- Latency: from a clean raw rise, tick and the count update occur on the same clock edge, 2 + FILTER_CYCLES + 1 cycles after the first rising WF_CLK edge that samples encdr=1.
- Count update on an accepted edge (dir sampled in that cycle):
  - d = deg + STEP_DEG if dir=0, else deg - STEP_DEG.
  - If d >= 360: deg = d - 360, rev = rev + 1.
  - If d <= -360: deg = d + 360, rev = rev - 1.
  - Otherwise deg = d and rev is unchanged.
  - Mixed signs are legal (rev=1, deg=-1 means 359 degrees). Total position = rev*360 + deg.
- Saturation: if a wrap would take rev above +1023 or below -1024, rev and deg hold their values. tick still pulses.
- enable=0: rev and deg are cleared on the next clock and held at 0. No tick. The stall counter is cleared.
- Stall:
  - The counter increments each cycle while drive=1 and enable=1 and no tick occurs.
  - It clears on tick, on drive=0, or on enable=0.
  - stall asserts (registered) when the counter reaches STALL_CYCLES. The counter saturates there.
  - stall stays high until the next tick, drive=0, or enable=0, and deasserts the cycle after that event.
- Simultaneous events: rst overrides everything. If enable falls in the same cycle as an edge, enable=0 wins (clear, no tick).
- The drive input has no effect on counting. Edges are counted while coasting.

Test Plan:
1. Forward: enable=1, dir=0, 360 clean pulses (8 high / 8 low cycles) -> rev=1, deg=0, 360 ticks. A further 180 pulses -> rev=1, deg=180.
2. Reverse: start from zero, dir=1, 361 pulses -> rev=-1, deg=-1. Then dir=0, 1 pulse -> rev=-1, deg=0.
3. Glitch filter with FILTER_CYCLES=4: a 2-cycle high glitch -> no tick, counts unchanged. A 5-cycle high pulse -> exactly 1 tick, arriving 7 cycles after the sampled rise.
4. Stall with STALL_CYCLES=100: drive=1, enable=1, no pulses -> stall=1 at cycle 100. One pulse -> stall=0 the cycle after the tick. drive=0 also clears stall.
5. Enable and reset:
   - rev=3, deg=45, drop enable -> rev=deg=0 next clock; pulses while disabled -> counts stay 0.
   - Assert rst mid-pulse -> all outputs 0 immediately (asynchronously).
6. Saturation: preload via 1023*360+359 forward pulses (or force), then 1 forward pulse -> rev=1023, deg=359 held, tick=1.
